// File: rtl/sram_pkg.sv
// sram_pkg: shared SRAM geometry, byte-lane layout and sprite-writer FSM states.
package sram_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int PIX_W  = 8;
    // Even pixel sits in the low byte, odd pixel in the high byte of each word.
    localparam int LOW_LANE  = 0;
    localparam int HIGH_LANE = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        SETUP,
        WRITE,
        HOLD,
        DONE
    } state_t;
endpackage

// File: rtl/sram_sprite_writer.sv
// sram_sprite_writer: packs 8-bit pixels two per word and writes them to async SRAM
// with a fixed SETUP/WRITE/HOLD cycle, starting from a programmable base address.
module sram_sprite_writer #(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int LEN_W  = 21
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [LEN_W-1:0]           pix_count,
    input  logic [sram_pkg::PIX_W-1:0] pix_data,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N,
    output logic                       SRAM_OE_N,
    output logic                       SRAM_WE_N,
    output logic [ADDR_W-1:0]          SRAM_ADDR,
    output logic [sram_pkg::DATA_W-1:0] SRAM_DQ_OUT,
    output logic                       SRAM_DQ_OE
);
    import sram_pkg::*;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   word;
    logic [LEN_W-1:0]    remaining;
    logic                hi_en;
    logic                in_cycle;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (pix_count == '0) ? DONE : LOW;
            LOW:     if (pix_valid) state_nx = (remaining == LEN_W'(1)) ? SETUP : HIGH;
            HIGH:    if (pix_valid) state_nx = SETUP;
            SETUP:   state_nx = WRITE;
            WRITE:   state_nx = HOLD;
            HOLD:    state_nx = (remaining == '0) ? DONE : LOW;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            addr      <= '0;
            word      <= '0;
            remaining <= '0;
            hi_en     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= pix_count;
                end
                LOW: if (pix_valid) begin
                    word      <= {{PIX_W{1'b0}}, pix_data};
                    remaining <= remaining - LEN_W'(1);
                    hi_en     <= 1'b0;
                end
                HIGH: if (pix_valid) begin
                    word[HIGH_LANE*PIX_W +: PIX_W] <= pix_data;
                    remaining <= remaining - LEN_W'(1);
                    hi_en     <= 1'b1;
                end
                HOLD:    addr <= addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Every strobe is a pure decode of the state register, so reset idles the bus at once.
    assign in_cycle    = (state == SETUP) || (state == WRITE) || (state == HOLD);
    assign pix_ready   = (state == LOW) || (state == HIGH);
    assign busy        = pix_ready || in_cycle;
    assign done        = (state == DONE);
    assign SRAM_CE_N   = !in_cycle;
    assign SRAM_LB_N   = !in_cycle;
    assign SRAM_UB_N   = !(in_cycle && hi_en);
    assign SRAM_WE_N   = (state != WRITE);
    assign SRAM_OE_N   = 1'b1;
    assign SRAM_DQ_OE  = in_cycle;
    assign SRAM_ADDR   = addr;
    assign SRAM_DQ_OUT = word;
endmodule

// File: tb/tb_sram_sprite_writer.sv
// tb_sram_sprite_writer: directed and randomized transfers checked against a byte-level
// memory model built from the pixel list, base address and modulo addressing.
module tb_sram_sprite_writer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [20:0] pix_count = '0;
    logic [7:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready, busy, done;
    logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;

    sram_sprite_writer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
        .pix_count(pix_count), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .done(done),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Observed SRAM contents (key = word_addr*2 + lane) and write-protocol bookkeeping.
    logic [7:0] dut_b[int];
    logic [7:0] exp_b[int];
    int n_wr, n_ce, first_we, last_we, proto_err;
    logic p_ce = 1'b1, p_we = 1'b1, p_oe = 1'b0, chk_hold = 1'b0;
    logic [19:0] p_addr, h_addr;
    logic [15:0] p_data, h_data;

    always @(negedge Clk) begin
        if (!SRAM_WE_N) begin
            if (!SRAM_LB_N) dut_b[int'(SRAM_ADDR)*2]     = SRAM_DQ_OUT[7:0];
            if (!SRAM_UB_N) dut_b[int'(SRAM_ADDR)*2 + 1] = SRAM_DQ_OUT[15:8];
            n_wr++;
            last_we = cyc;
            if (first_we < 0) first_we = cyc;
            if (!(p_ce == 1'b0 && p_we == 1'b1 && p_oe && p_addr == SRAM_ADDR &&
                  p_data == SRAM_DQ_OUT && !SRAM_CE_N && SRAM_DQ_OE)) proto_err++;
            chk_hold = 1'b1;
            h_addr = SRAM_ADDR;
            h_data = SRAM_DQ_OUT;
        end else if (chk_hold) begin
            if (!(!SRAM_CE_N && SRAM_DQ_OE && SRAM_ADDR == h_addr && SRAM_DQ_OUT == h_data))
                proto_err++;
            chk_hold = 1'b0;
        end
        if (SRAM_OE_N !== 1'b1) proto_err++;
        if (!SRAM_CE_N) n_ce++;
        p_ce = SRAM_CE_N;
        p_we = SRAM_WE_N;
        p_oe = SRAM_DQ_OE;
        p_addr = SRAM_ADDR;
        p_data = SRAM_DQ_OUT;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [7:0] px[$];

    // Runs one transfer of px[] to base; gap_pct is the chance of idling pix_valid,
    // stall inserts a 10-cycle pix_valid=0 gap between the first and second pixel.
    task automatic run_xfer(input logic [19:0] base, input int gap_pct, input bit stall);
        int n, idx, guard, hs1, s_cyc, mism;
        logic v, rdy;
        n = px.size();
        dut_b.delete();
        exp_b.delete();
        for (int i = 0; i < n; i++) exp_b[((int'(base) + i/2) & 32'hFFFFF)*2 + i%2] = px[i];
        n_wr = 0; n_ce = 0; first_we = -1; last_we = -1; proto_err = 0; hs1 = -1;
        start = 1'b1; base_addr = base; pix_count = 21'(n);
        s_cyc = cyc;
        tick();
        start = 1'b0;
        base_addr = $urandom; pix_count = 21'($urandom);
        check("busy_after_start", busy, n != 0);
        check("ready_after_start", pix_ready, n != 0);
        if (n == 0) begin
            check("done_cnt0", done, 1);
            check("done_cnt0_cycle", cyc, s_cyc + 1);
            tick();
            check("done_cnt0_pulse", done, 0);
            check("cnt0_no_ce", n_ce, 0);
            check("cnt0_no_wr", n_wr, 0);
            return;
        end
        idx = 0; guard = 0;
        while (idx < n && guard < 3000) begin
            if (stall && idx == 1) begin
                stall = 1'b0;
                pix_valid = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (SRAM_CE_N !== 1'b1 || pix_ready !== 1'b1) proto_err++;
                end
            end
            v = ($urandom_range(99) >= gap_pct);
            pix_valid = v;
            pix_data = v ? px[idx] : 8'($urandom);
            rdy = pix_ready;
            if (v && rdy && idx == 1) hs1 = cyc;
            @(posedge Clk);
            if (v && rdy) idx++;
            #1;
            guard++;
        end
        pix_valid = 1'b0;
        check("all_pixels_taken", idx, n);
        guard = 0;
        while (!done && guard < 40) begin
            tick();
            guard++;
        end
        check("done_seen", done, 1);
        check("done_after_hold", cyc, last_we + 2);
        if (hs1 >= 0) check("we_after_2nd_pixel", first_we, hs1 + 2);
        check("word_writes", n_wr, (n + 1) / 2);
        check("protocol", proto_err, 0);
        mism = 0;
        foreach (exp_b[k]) if (!dut_b.exists(k) || dut_b[k] !== exp_b[k]) mism++;
        check("mem_bytes", mism, 0);
        check("mem_size", dut_b.num(), exp_b.num());
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int g;
        #2;
        check("rst_ce_n", SRAM_CE_N, 1);
        check("rst_ub_lb_oe_we", {SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N}, 4'hF);
        check("rst_addr", SRAM_ADDR, 0);
        check("rst_dq", SRAM_DQ_OUT, 0);
        check("rst_flags", {SRAM_DQ_OE, pix_ready, busy, done}, 0);
        tick(); tick();
        Reset = 1'b0;
        tick();
        check("idle_ready", pix_ready, 0);

        px = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer(20'h00100, 0, 0);
        check("word_100", {dut_b[32'h201], dut_b[32'h200]}, 16'h2211);
        check("word_101", {dut_b[32'h203], dut_b[32'h202]}, 16'h4433);

        px = '{8'hAA, 8'hBB, 8'hCC};
        run_xfer(20'h00200, 0, 0);
        check("odd_high_unwritten", dut_b.exists(32'h403), 0);

        px = '{};
        run_xfer(20'h00300, 0, 0);

        px = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        run_xfer(20'hFFFFF, 0, 0);
        check("wrap_word0", {dut_b[32'h1FFFFF], dut_b[32'h1FFFFE]}, 16'hA55A);
        check("wrap_word1", {dut_b[32'h1], dut_b[32'h0]}, 16'hC33C);

        px = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer(20'h00100, 0, 1);

        for (int t = 0; t < 8; t++) begin
            px.delete();
            repeat ($urandom_range(9)) px.push_back(8'($urandom));
            run_xfer(20'($urandom), 40, 0);
        end

        start = 1'b1; base_addr = 20'h00400; pix_count = 21'd2;
        tick();
        start = 1'b0;
        pix_valid = 1'b1; pix_data = 8'h77;
        g = 0;
        while (SRAM_WE_N && g < 20) begin
            tick();
            g++;
        end
        pix_valid = 1'b0;
        check("reached_write", SRAM_WE_N, 0);
        #3 Reset = 1'b1;
        #1;
        check("rst_async_we", SRAM_WE_N, 1);
        check("rst_async_oe", SRAM_DQ_OE, 0);
        check("rst_async_busy", busy, 0);
        tick();
        check("rst_no_done", done, 0);
        tick();
        Reset = 1'b0;
        tick();
        check("post_rst_done", done, 0);
        px = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_xfer(20'h00500, 20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
